mul_sched: RTL and testbench
============================

# mul_sched

Scheduler that shares the single radix-8 Booth multiplier among `NREQ` requesters. Each requester hands over a 32-bit operand pair with a valid/ready handshake. The scheduler grants requesters round-robin and issues one `mul_start` pulse per grant. It waits for `mul_done` under a watchdog timeout, then returns the 67-bit product to the owning requester with a second valid/ready handshake. It sits between the execute-stage requesters and the multiplier datapath; only one multiplication is in flight at a time.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 32: operand width.
- `PW`, 67: product width, matching the multiplier output.
- `TIMEOUT`, 64: maximum cycles spent waiting for `mul_done` before aborting.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  operand pair valid, one bit per requester.
- `req_ready`  out  NREQ  grant/accept, at most one bit set.
- `req_x`, `req_y`  in  NREQ*W  packed operands; requester i uses `[i*W +: W]`.
- `rsp_valid`  out  NREQ  result valid for the owning requester, at most one bit set.
- `rsp_ready`  in  NREQ  requester accepts the result.
- `rsp_product`  out  PW  result, shared by all requesters.
- `rsp_err`  out  1  result is a timeout abort; `rsp_product` is 0 when set.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_x`, `mul_y`  out  W  registered operands, stable from ISSUE through BUSY.
- `mul_done`  in  1  multiplier completion strobe.
- `mul_product`  in  PW  valid in the cycle `mul_done` is high.

## Operation
States:
- IDLE
  - Arbitration is combinational: the winner is the first `req_valid` bit searching upward (with wrap) from `ptr+1`.
  - `req_ready[winner]` = 1; all other ready bits are 0.
  - On `req_valid & req_ready`: capture operands into `mul_x`/`mul_y`, record `owner`, go to ISSUE.
  - No valid requests: stay in IDLE, `req_ready` = 0.
- ISSUE
  - `mul_start` = 1 for exactly this cycle.
  - Clear the watchdog counter `wd`, go to BUSY.
- BUSY
  - `wd` increments every cycle.
  - `mul_done` = 1: capture `mul_product`, clear the error flag, go to RESP.
  - Otherwise, if `wd == TIMEOUT-1`: load product 0, set the error flag, go to RESP.
  - If `mul_done` coincides with the timeout, `mul_done` wins (no error).
- RESP
  - `rsp_valid[owner]` = 1; `rsp_product` and `rsp_err` are held stable.
  - On `rsp_ready[owner]`: set `ptr` <= `owner`, go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.

Rules:
- `mul_done` outside BUSY is ignored.
- A requester may drop `req_valid` before it is granted; nothing is captured.
- `req_ready` is 0 in every state except IDLE, so there is no back-to-back accept.
- `ptr` update gives the just-served requester lowest priority next time. Requester `owner` can be served again only after every other valid requester has had a turn.
- `wd` width is `$clog2(TIMEOUT)`; it never wraps, because the BUSY exit happens at `TIMEOUT-1`.

## Timing
- Reset (async assert, sync deassert at the source) sets:
  - state = IDLE, `ptr` = NREQ-1 (requester 0 has first priority), `owner` = 0, `wd` = 0;
  - `mul_x`/`mul_y` = 0, `rsp_product` = 0, `rsp_err` = 0, `mul_start` = 0.
  - `req_ready` and `rsp_valid` are decoded from state, so they are 0 during reset.
- Reset mid-operation discards the in-flight job. No response is produced; the multiplier is left to finish and its `mul_done` is ignored.
- Latency: accept at edge T, `mul_start` high in cycle T+1, BUSY from T+2.
  - `rsp_valid` rises one cycle after the `mul_done` cycle.
  - Earliest next accept is one cycle after the response handshake.
- Outputs `mul_start`, `mul_x`, `mul_y`, `rsp_product` and `rsp_err` are registered. `req_ready` and `rsp_valid` are a state decode plus the arbiter.

## Structure
- Package `mul_pkg`:
  - state enum `sched_state_t` {IDLE, ISSUE, BUSY, RESP};
  - localparams `MUL_W` = 32 and `MUL_PW` = 67;
  - default `MUL_TIMEOUT` = 64.
- Sub-module `rr_arbiter`: combinational, with inputs `req`[NREQ] and `ptr`, and outputs `gnt` (one-hot) and `gnt_idx`. It is reusable for the CSkA adder-sharing path.
- The top level holds the FSM, operand/result registers, the watchdog and the `ptr` register.

## Test plan
- Single request: requester 2 sends X=172, Y=172 and `mul_done` returns 29584 after 30 cycles.
  - Expect one `mul_start` pulse, `mul_x`=`mul_y`=172.
  - Expect `rsp_valid[2]` with product 29584 and `rsp_err`=0.
- Fairness: all four `req_valid` held high from reset.
  - Expect grant order 0,1,2,3,0.
  - Expect no grant while any `rsp_valid` bit is high.
- Timeout: no `mul_done` after start.
  - Expect `rsp_valid` exactly TIMEOUT cycles after BUSY entry, with `rsp_err`=1 and product 0.
  - Expect the next request to be served normally.
- Simultaneous done and timeout: `mul_done` asserted in the `wd == TIMEOUT-1` cycle.
  - Expect `rsp_err`=0 and the captured product.
- Response backpressure: `rsp_ready` held low for 10 cycles while other requesters are valid.
  - Expect `rsp_product` stable and `req_ready` = 0 throughout.
  - Expect a stray `rsp_ready` from a non-owner to have no effect.
- Reset mid-BUSY, then a late `mul_done`.
  - Expect all outputs 0 and no `rsp_valid`.
  - Expect requester 0 to be granted first afterwards.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier-sharing scheduler.
//   sched_state_t : scheduler FSM states
//   MUL_W/MUL_PW  : operand and product widths of the radix-8 Booth multiplier
//   MUL_TIMEOUT   : default watchdog limit, in cycles spent waiting for done
package mul_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} sched_state_t;

   localparam int MUL_W       = 32;
   localparam int MUL_PW      = 67;
   localparam int MUL_TIMEOUT = 64;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, also reused by the adder-sharing path.
//   req     : request vector, one bit per requester
//   ptr     : last served requester; the search starts at ptr+1 and wraps
//   gnt     : one-hot grant, all zero when nothing is requested
//   gnt_idx : index of the granted requester (0 when nothing is requested)
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PTRW-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PTRW-1:0] gnt_idx
);

   logic [PTRW-1:0] idx;
   logic            found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = ptr;
      // Walk ptr+1, ptr+2, ... with explicit wrap so non-power-of-two NREQ works.
      for (int k = 0; k < NREQ; k++) begin
         idx = (idx == PTRW'(NREQ-1)) ? '0 : idx + 1'b1;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/mul_sched.sv
// Shares one multiplier among NREQ requesters, one job in flight at a time.
//   clk, rst_b             : clock, asynchronous active-low reset
//   req_valid/ready/x/y    : operand handshake per requester (packed operands)
//   rsp_valid/ready        : result handshake per requester
//   rsp_product, rsp_err   : registered result, err marks a watchdog abort
//   mul_start, mul_x/y     : registered start pulse and operands to multiplier
//   mul_done, mul_product  : completion strobe and product from multiplier
module mul_sched
   import mul_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = MUL_W,
   parameter int PW      = MUL_PW,
   parameter int TIMEOUT = MUL_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_x,
   input  logic [NREQ*W-1:0] req_y,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [PW-1:0]     rsp_product,
   output logic              rsp_err,
   output logic              mul_start,
   output logic [W-1:0]      mul_x,
   output logic [W-1:0]      mul_y,
   input  logic              mul_done,
   input  logic [PW-1:0]     mul_product
);

   localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW  = $clog2(TIMEOUT);

   sched_state_t    state_q, state_d;
   logic [PTRW-1:0] ptr_q, ptr_d;
   logic [PTRW-1:0] owner_q, owner_d;
   logic [WDW-1:0]  wd_q, wd_d;
   logic [W-1:0]    x_q, x_d, y_q, y_d;
   logic [PW-1:0]   prod_q, prod_d;
   logic            err_q, err_d;
   logic            start_q, start_d;

   logic [NREQ-1:0] gnt;
   logic [PTRW-1:0] gnt_idx;

   rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // The arbiter always grants when any request is valid, so an IDLE cycle
   // with a valid request is always an accept.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      wd_d    = wd_q;
      x_d     = x_q;
      y_d     = y_q;
      prod_d  = prod_q;
      err_d   = err_q;
      start_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               owner_d = gnt_idx;
               start_d = 1'b1;
               state_d = ISSUE;
               for (int i = 0; i < NREQ; i++) begin
                  if (gnt[i]) begin
                     x_d = req_x[i*W +: W];
                     y_d = req_y[i*W +: W];
                  end
               end
            end
         end
         ISSUE: begin
            wd_d    = '0;
            state_d = BUSY;
         end
         BUSY: begin
            if (mul_done) begin
               prod_d  = mul_product;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (wd_q == WDW'(TIMEOUT-1)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready[owner_q]) begin
               ptr_d   = owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         ptr_q   <= PTRW'(NREQ-1);
         owner_q <= '0;
         wd_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         prod_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         wd_q    <= wd_d;
         x_q     <= x_d;
         y_q     <= y_d;
         prod_q  <= prod_d;
         err_q   <= err_d;
         start_q <= start_d;
      end
   end

   // Reset parks the FSM in IDLE, so ready is also masked by rst_b to keep
   // requesters from seeing a grant while reset is held.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state_q == IDLE && rst_b) req_ready = gnt;
      for (int i = 0; i < NREQ; i++)
         rsp_valid[i] = (state_q == RESP) && (owner_q == PTRW'(i));
   end

   assign rsp_product = prod_q;
   assign rsp_err     = err_q;
   assign mul_start   = start_q;
   assign mul_x       = x_q;
   assign mul_y       = y_q;

endmodule

// File: tb/tb_mul_sched.sv
module tb_mul_sched;
   localparam int NREQ = 4, W = 32, PW = 67, TO = 64;

   logic              clk = 1'b0;
   logic              rst_b;
   logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NREQ*W-1:0] req_x, req_y;
   logic [PW-1:0]     rsp_product, mul_product;
   logic              rsp_err, mul_start, mul_done;
   logic [W-1:0]      mul_x, mul_y;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mul_sched #(.NREQ(NREQ), .W(W), .PW(PW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_b(rst_b),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_product(rsp_product), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
      .mul_done(mul_done), .mul_product(mul_product)
   );

   task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NREQ-1:0] oh(input int r);
      logic [NREQ-1:0] v;
      v = '0;
      v[r] = 1'b1;
      return v;
   endfunction

   task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
      req_x[i*W +: W] = x;
      req_y[i*W +: W] = y;
   endtask

   // Called in the ISSUE cycle; returns in the first RESP cycle. Done is
   // raised in the BUSY cycle where the watchdog reads k.
   task automatic busy_done(input int k, input logic [PW-1:0] p);
      tick();
      chk("start_one_pulse", mul_start, 1'b0);
      repeat (k) tick();
      mul_done = 1'b1;
      mul_product = p;
      tick();
      mul_done = 1'b0;
      mul_product = '0;
   endtask

   task automatic resp(input string tag, input int r, input logic [PW-1:0] p, input logic e);
      chk({tag, "_rsp_valid"}, rsp_valid, oh(r));
      chk({tag, "_product"}, rsp_product, p);
      chk({tag, "_err"}, rsp_err, e);
      chk({tag, "_no_grant"}, req_ready, '0);
      rsp_ready = oh(r);
      tick();
      rsp_ready = '0;
      chk({tag, "_rsp_drop"}, rsp_valid, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [PW-1:0] p;
      int order [5];
      order = '{0, 1, 2, 3, 0};

      rst_b = 1'b0;
      req_valid = 4'hF;
      req_x = '0; req_y = '0;
      rsp_ready = '0;
      mul_done = 1'b0; mul_product = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_mul_start", mul_start, 1'b0);
      chk("rst_mul_x", mul_x, '0);
      chk("rst_mul_y", mul_y, '0);
      chk("rst_product", rsp_product, '0);
      chk("rst_err", rsp_err, 1'b0);
      req_valid = '0;
      rst_b = 1'b1;
      tick();

      // single request from requester 2
      set_ops(2, 172, 172);
      req_valid = 4'b0100;
      #1 chk("single_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      chk("single_start", mul_start, 1'b1);
      chk("single_x", mul_x, 172);
      chk("single_y", mul_y, 172);
      busy_done(28, 29584);
      resp("single", 2, 29584, 1'b0);

      // fairness from reset with all requesters valid
      for (int i = 0; i < NREQ; i++) set_ops(i, 10 + i, 20 + i);
      rst_b = 1'b0;
      req_valid = 4'hF;
      #1 chk("rst2_req_ready", req_ready, '0);
      tick();
      rst_b = 1'b1;
      for (int n = 0; n < 5; n++) begin
         #1 chk("rr_grant", req_ready, oh(order[n]));
         tick();
         chk("rr_start", mul_start, 1'b1);
         chk("rr_x", mul_x, 10 + order[n]);
         busy_done(2, (10 + order[n]) * (20 + order[n]));
         resp("rr", order[n], (10 + order[n]) * (20 + order[n]), 1'b0);
      end

      // watchdog abort on requester 1 (ptr now 0)
      req_valid = 4'b0010;
      #1 chk("to_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      tick();
      repeat (TO - 1) tick();
      chk("to_not_early", rsp_valid, '0);
      tick();
      resp("timeout", 1, '0, 1'b1);

      // next request served normally: ptr=1, so requester 3
      req_valid = 4'b1000;
      #1 chk("after_to_ready", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      chk("after_to_start", mul_start, 1'b1);
      busy_done(4, 299);
      resp("after_to", 3, 299, 1'b0);

      // done in the same cycle as the watchdog limit
      p = 67'h4_0000_0000_0000_0003;
      req_valid = 4'b0001;
      #1 chk("sim_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      busy_done(TO - 1, p);
      resp("sim", 0, p, 1'b0);

      // response backpressure with other requesters waiting
      p = 67'h1234_5678_9ABC;
      req_valid = 4'b1110;
      #1 chk("bp_ready", req_ready, 4'b0010);
      tick();
      busy_done(5, p);
      for (int c = 0; c < 10; c++) begin
         rsp_ready = (c % 2 == 1) ? 4'b1101 : 4'b0000;
         #1;
         chk("bp_valid", rsp_valid, 4'b0010);
         chk("bp_product", rsp_product, p);
         chk("bp_no_ready", req_ready, '0);
         tick();
      end
      rsp_ready = '0;
      resp("bp", 1, p, 1'b0);
      #1 chk("bp_next_grant", req_ready, 4'b0100);

      // reset during BUSY, then a late done
      tick();
      chk("pre_rst_x", mul_x, 12);
      tick();
      tick();
      rst_b = 1'b0;
      req_valid = '0;
      #1;
      chk("mid_rst_start", mul_start, 1'b0);
      chk("mid_rst_x", mul_x, '0);
      chk("mid_rst_y", mul_y, '0);
      chk("mid_rst_product", rsp_product, '0);
      chk("mid_rst_err", rsp_err, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, '0);
      chk("mid_rst_req_ready", req_ready, '0);
      tick();
      rst_b = 1'b1;
      tick();
      mul_done = 1'b1;
      mul_product = 67'h7_7777;
      tick();
      mul_done = 1'b0;
      mul_product = '0;
      chk("late_done_rsp_valid", rsp_valid, '0);
      chk("late_done_product", rsp_product, '0);
      chk("late_done_start", mul_start, 1'b0);
      req_valid = 4'hF;
      #1 chk("post_rst_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      chk("post_rst_x", mul_x, 10);
      busy_done(3, 200);
      resp("post_rst", 0, 200, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
